// File: rtl/draw_pkg.sv
// Shared drawing types: RGB layout, flash sequencer states and colour constants.
package draw_pkg;

    localparam int COLOR_W_DEFAULT = 8;
    localparam int RGB_W_DEFAULT   = 3 * COLOR_W_DEFAULT;

    typedef struct packed {
        logic [COLOR_W_DEFAULT-1:0] r;
        logic [COLOR_W_DEFAULT-1:0] g;
        logic [COLOR_W_DEFAULT-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FLASH = 2'd2
    } flash_state_t;

    localparam logic WHITE_BIT = 1'b1;
    localparam logic BLACK_BIT = 1'b0;
    localparam rgb_t WHITE = '{r: '1, g: '1, b: '1};
    localparam rgb_t BLACK = '{r: '0, g: '0, b: '0};

    function automatic int rgb_width(input int color_w);
        return 3 * color_w;
    endfunction

endpackage

// File: rtl/flash_ctrl.sv
// Game-over flash sequencer: arms on game_over rise, then alternates white/normal
// on successive frames (vsync rises) for FLASH_FRAMES frames.
module flash_ctrl
    import draw_pkg::*;
#(
    parameter int FLASH_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    input  logic game_over,
    output logic flash_white,
    output logic flash_active
);

    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    flash_state_t     state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             vsync_prev_reg, go_prev_reg;
    logic             vsync_rise, go_rise;

    assign vsync_rise = vsync_in & ~vsync_prev_reg;
    assign go_rise    = game_over & ~go_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            vsync_prev_reg <= 1'b0;
            go_prev_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            vsync_prev_reg <= vsync_in;
            go_prev_reg    <= game_over;
        end
    end

    // A game_over rise coinciding with a frame start only arms; flashing begins next frame.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (go_rise) state_next = ARMED;
            end
            ARMED: begin
                if (vsync_rise) begin
                    state_next = FLASH;
                    count_next = '0;
                end
            end
            FLASH: begin
                if (vsync_rise) begin
                    if (count_reg == CNT_W'(FLASH_FRAMES - 1)) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign flash_active = (state_reg == FLASH);
    assign flash_white  = flash_active & ~count_reg[0];

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage layer compositor: priority select, then blanking/flash/dim effects.
// Optional half-brightness pause dimming is enabled by defining PAUSE_DIM_EN.
module pixel_compositor
    import draw_pkg::*;
#(
    parameter int                       NUM_LAYERS   = 4,
    parameter int                       COLOR_W      = COLOR_W_DEFAULT,
    parameter int                       FLASH_FRAMES = 8,
    parameter logic [3*COLOR_W-1:0]     BG_COLOR     = 24'h0000FF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_LAYERS-1:0]           layer_hit,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_color,
    input  logic                            pix_valid_in,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            game_over,
    input  logic                            pause,
    output logic [COLOR_W-1:0]              VGA_R,
    output logic [COLOR_W-1:0]              VGA_G,
    output logic [COLOR_W-1:0]              VGA_B,
    output logic                            pix_valid_out,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            flash_active
);

    localparam int RGB_W = rgb_width(COLOR_W);

    logic [RGB_W-1:0] layer_rgb [NUM_LAYERS];
    logic [RGB_W-1:0] sel_rgb;
    logic             flash_white, flash_on;

    logic [RGB_W-1:0] color_s1_reg;
    logic             valid_s1_reg, hsync_s1_reg, vsync_s1_reg;
    logic             white_s1_reg, active_s1_reg;

    logic [RGB_W-1:0] pix_next;
    logic [RGB_W-1:0] rgb_reg;
    logic             valid_reg, hsync_reg, vsync_reg, active_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
            assign layer_rgb[gi] = layer_color[gi*RGB_W +: RGB_W];
        end
    endgenerate

    // Walk from lowest to highest priority so layer 0 wins last.
    always_comb begin
        sel_rgb = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i]) sel_rgb = layer_rgb[i];
        end
    end

    flash_ctrl #(
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_flash (
        .clk         (clk),
        .reset       (reset),
        .vsync_in    (vsync_in),
        .game_over   (game_over),
        .flash_white (flash_white),
        .flash_active(flash_on)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            color_s1_reg  <= '0;
            valid_s1_reg  <= 1'b0;
            hsync_s1_reg  <= 1'b0;
            vsync_s1_reg  <= 1'b0;
            white_s1_reg  <= 1'b0;
            active_s1_reg <= 1'b0;
        end else begin
            color_s1_reg  <= sel_rgb;
            valid_s1_reg  <= pix_valid_in;
            hsync_s1_reg  <= hsync_in;
            vsync_s1_reg  <= vsync_in;
            white_s1_reg  <= flash_white;
            active_s1_reg <= flash_on;
        end
    end

`ifdef PAUSE_DIM_EN
    logic             pause_s1_reg;
    logic [RGB_W-1:0] dim_rgb;

    always_ff @(posedge clk) begin
        if (reset) pause_s1_reg <= 1'b0;
        else       pause_s1_reg <= pause;
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_dim
            assign dim_rgb[gi*COLOR_W +: COLOR_W] = color_s1_reg[gi*COLOR_W +: COLOR_W] >> 1;
        end
    endgenerate
`else
    logic unused_pause;
    assign unused_pause = pause;
`endif

    always_comb begin
        pix_next = color_s1_reg;
`ifdef PAUSE_DIM_EN
        if (pause_s1_reg) pix_next = dim_rgb;
`endif
        if (!valid_s1_reg)     pix_next = {RGB_W{BLACK_BIT}};
        else if (white_s1_reg) pix_next = {RGB_W{WHITE_BIT}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg    <= '0;
            valid_reg  <= 1'b0;
            hsync_reg  <= 1'b0;
            vsync_reg  <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            rgb_reg    <= pix_next;
            valid_reg  <= valid_s1_reg;
            hsync_reg  <= hsync_s1_reg;
            vsync_reg  <= vsync_s1_reg;
            active_reg <= active_s1_reg;
        end
    end

    assign VGA_R         = rgb_reg[2*COLOR_W +: COLOR_W];
    assign VGA_G         = rgb_reg[COLOR_W +: COLOR_W];
    assign VGA_B         = rgb_reg[0 +: COLOR_W];
    assign pix_valid_out = valid_reg;
    assign hsync_out     = hsync_reg;
    assign vsync_out     = vsync_reg;
    assign flash_active  = active_reg;

endmodule
